// File: rtl/debugger_rx_cmd.sv
// -----------------------------------------------------------------------------
// debugger_rx_cmd
//   Command receiver sitting between the UART RX FIFO and the MIPS pipeline /
//   debug TX path. Pops one opcode byte at a time, drives pipeline run /
//   single-step / reset control, and builds a DATA_BYTES-wide payload (echo
//   or debug snapshot) that is handed to the TX module with send/done.
//
// Parameters
//   DATA_BYTES   payload length in bytes, payload width PW = 8*DATA_BYTES
//   ECHO_INC     value added (mod 256) to the echoed byte before replication
//   RESET_CYCLES cycles pipeline_reset is held by the RESET command (>= 1)
//
// Ports
//   clk              system clock, rising edge
//   global_reset_n   asynchronous active-low reset
//   r_data           head byte of the RX FIFO, valid while rx_ready=1
//   rx_ready         RX FIFO non-empty
//   program_finished pipeline reached end of program (level)
//   dbg_data         pipeline debug snapshot, sampled on dump
//   data_sent        TX finished current payload (one-cycle pulse)
//   rd_uart          one-cycle pop strobe to the RX FIFO
//   pipeline_reset   pipeline synchronous reset request
//   pipeline_clk_en  pipeline clock enable
//   send_signal      one-cycle strobe: sendData valid, start TX
//   sendData         payload to TX module
//   cmd_error        one-cycle pulse on an unknown opcode
//   current_state    FSM state encoding, for LEDs/debug
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module debugger_rx_cmd #(
  parameter int DATA_BYTES   = 215,
  parameter int ECHO_INC     = 1,
  parameter int RESET_CYCLES = 4,
  localparam int PW          = 8 * DATA_BYTES
) (
  input  logic          clk,
  input  logic          global_reset_n,
  input  logic [7:0]    r_data,
  input  logic          rx_ready,
  input  logic          program_finished,
  input  logic [PW-1:0] dbg_data,
  input  logic          data_sent,
  output logic          rd_uart,
  output logic          pipeline_reset,
  output logic          pipeline_clk_en,
  output logic          send_signal,
  output logic [PW-1:0] sendData,
  output logic          cmd_error,
  output logic [2:0]    current_state
);

  localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DECODE  = 3'd1,
    S_RUN     = 3'd2,
    S_STEP    = 3'd3,
    S_PRST    = 3'd4,
    S_ECHO    = 3'd5,
    S_SEND    = 3'd6,
    S_WAIT_TX = 3'd7
  } state_t;

  localparam logic [7:0] OP_RUN   = 8'h01;
  localparam logic [7:0] OP_STEP  = 8'h02;
  localparam logic [7:0] OP_RESET = 8'h03;
  localparam logic [7:0] OP_ECHO  = 8'h04;
  localparam logic [7:0] OP_DUMP  = 8'h05;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_byte;       // last popped byte: opcode, or echo operand
  logic            r_phase;      // second-cycle flag for STEP and ECHO
  logic            w_phase_next;
  logic [CW-1:0]   r_cnt;        // PRST cycle counter
  logic [CW-1:0]   w_cnt_next;
  logic [PW-1:0]   r_send_data;
  logic            w_pop;
  logic            w_load_dbg;
  logic            w_load_echo;
  logic [7:0]      w_echo_byte;

  // Carry out of the 8-bit add is dropped, so 0xFF + 1 wraps to 0x00.
  assign w_echo_byte = r_byte + 8'(ECHO_INC);

  // NOTE: every output of this block gets a default before the case, so no
  // path through it leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next          = r_state;
    w_phase_next    = r_phase;
    w_cnt_next      = r_cnt;
    w_pop           = 1'b0;
    w_load_dbg      = 1'b0;
    w_load_echo     = 1'b0;
    pipeline_reset  = 1'b0;
    pipeline_clk_en = 1'b0;
    send_signal     = 1'b0;
    cmd_error       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (rx_ready) begin
          w_pop  = 1'b1;
          w_next = S_DECODE;
        end
      end

      S_DECODE: begin
        case (r_byte)
          OP_RUN:   w_next = S_RUN;
          OP_STEP:  w_next = S_STEP;
          OP_RESET: w_next = S_PRST;
          OP_ECHO:  w_next = S_ECHO;
          OP_DUMP: begin
            w_load_dbg = 1'b1;
            w_next     = S_SEND;
          end
          default: begin
            cmd_error = 1'b1;
            w_next    = S_IDLE;
          end
        endcase
      end

      // Enable is a function of the live program_finished level, so a
      // program that is already finished on entry gets no enable cycle.
      S_RUN: begin
        if (program_finished) begin
          w_load_dbg = 1'b1;
          w_next     = S_SEND;
        end else begin
          pipeline_clk_en = 1'b1;
        end
      end

      // Phase 0 clocks the pipeline once; phase 1 samples the result.
      S_STEP: begin
        if (!r_phase) begin
          pipeline_clk_en = 1'b1;
          w_phase_next    = 1'b1;
        end else begin
          w_load_dbg   = 1'b1;
          w_phase_next = 1'b0;
          w_next       = S_SEND;
        end
      end

      S_PRST: begin
        pipeline_reset = 1'b1;
        if (r_cnt == CW'(RESET_CYCLES - 1)) begin
          w_cnt_next = '0;
          w_next     = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end

      // Phase 0 waits for and pops the operand; phase 1 builds the payload
      // from the registered byte.
      S_ECHO: begin
        if (!r_phase) begin
          if (rx_ready) begin
            w_pop        = 1'b1;
            w_phase_next = 1'b1;
          end
        end else begin
          w_load_echo  = 1'b1;
          w_phase_next = 1'b0;
          w_next       = S_SEND;
        end
      end

      S_SEND: begin
        send_signal = 1'b1;
        w_next      = S_WAIT_TX;
      end

      S_WAIT_TX: begin
        if (data_sent) w_next = S_IDLE;
      end

      default: w_next = S_IDLE;
    endcase
  end

  // The pop strobe is combinational on rx_ready; gating with the reset keeps
  // it low while reset is held even if the FIFO is non-empty.
  assign rd_uart       = w_pop & global_reset_n;
  assign sendData      = r_send_data;
  assign current_state = r_state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      r_state     <= S_IDLE;
      r_byte      <= '0;
      r_phase     <= 1'b0;
      r_cnt       <= '0;
      r_send_data <= '0;
    end else begin
      r_state <= w_next;
      r_phase <= w_phase_next;
      r_cnt   <= w_cnt_next;
      if (w_pop) r_byte <= r_data;
      if (w_load_dbg)       r_send_data <= dbg_data;
      else if (w_load_echo) r_send_data <= {DATA_BYTES{w_echo_byte}};
    end
  end

endmodule

// File: tb/tb_debugger_rx_cmd.sv
// -----------------------------------------------------------------------------
// tb_debugger_rx_cmd
//   Directed bench for debugger_rx_cmd with DATA_BYTES=4, ECHO_INC=1,
//   RESET_CYCLES=4. A queue stands in for the RX FIFO; a per-cycle tick task
//   samples outputs on the falling edge, counts strobes, and pops the queue
//   after each rising edge on which rd_uart was high.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_debugger_rx_cmd;

  localparam int DB = 4;
  localparam int PW = 8 * DB;

  logic          clk = 1'b0;
  logic          global_reset_n;
  logic [7:0]    r_data;
  logic          rx_ready;
  logic          program_finished;
  logic [PW-1:0] dbg_data;
  logic          data_sent;
  logic          rd_uart;
  logic          pipeline_reset;
  logic          pipeline_clk_en;
  logic          send_signal;
  logic [PW-1:0] sendData;
  logic          cmd_error;
  logic [2:0]    current_state;

  debugger_rx_cmd #(
    .DATA_BYTES  (DB),
    .ECHO_INC    (1),
    .RESET_CYCLES(4)
  ) dut (
    .clk             (clk),
    .global_reset_n  (global_reset_n),
    .r_data          (r_data),
    .rx_ready        (rx_ready),
    .program_finished(program_finished),
    .dbg_data        (dbg_data),
    .data_sent       (data_sent),
    .rd_uart         (rd_uart),
    .pipeline_reset  (pipeline_reset),
    .pipeline_clk_en (pipeline_clk_en),
    .send_signal     (send_signal),
    .sendData        (sendData),
    .cmd_error       (cmd_error),
    .current_state   (current_state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q[$];
  int         cyc = 0;
  int         n_pop = 0, n_send = 0, n_clken = 0, n_prst = 0, n_err = 0;
  int         n_bad_pop = 0, n_overlap = 0;
  int         last_pop_cyc = 0, last_send_cyc = 0;
  logic [PW-1:0] send_val = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    rx_ready = (q.size() != 0);
    r_data   = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    drive_fifo();
  endtask

  // One clock cycle: sample at negedge, advance past posedge, update FIFO.
  task automatic tick();
    logic pop;
    @(negedge clk);
    if (rd_uart) begin
      n_pop++;
      last_pop_cyc = cyc;
      if (!rx_ready) n_bad_pop++;
    end
    if (send_signal) begin
      n_send++;
      last_send_cyc = cyc;
      send_val = sendData;
    end
    if (pipeline_clk_en) n_clken++;
    if (pipeline_reset) n_prst++;
    if (pipeline_reset && pipeline_clk_en) n_overlap++;
    if (cmd_error) n_err++;
    pop = rd_uart;
    @(posedge clk);
    #1;
    if (pop && q.size() > 0) void'(q.pop_front());
    drive_fifo();
    cyc++;
  endtask

  task automatic pulse_done();
    data_sent = 1'b1;
    tick();
    data_sent = 1'b0;
  endtask

  task automatic run_until_send(input string tag, input int budget);
    int start;
    start = n_send;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (n_send > start) break;
    end
    check(tag, (n_send > start) ? 64'd1 : 64'd0, 64'd1);
  endtask

  initial begin
    int p0, s0, c0, r0, e0;

    global_reset_n   = 1'b0;
    program_finished = 1'b0;
    dbg_data         = '0;
    data_sent        = 1'b0;
    drive_fifo();

    // ---------------- reset state ----------------
    repeat (2) tick();
    check("rst_state", current_state, 0);
    check("rst_outs", {rd_uart, pipeline_reset, pipeline_clk_en, send_signal, cmd_error}, 0);
    check("rst_senddata", sendData, 0);
    global_reset_n = 1'b1;
    tick();
    check("post_rst_idle", current_state, 0);

    // ---------------- echo 0x41 ----------------
    p0 = n_pop; s0 = n_send;
    push(8'h04);
    push(8'h41);
    run_until_send("echo_send_timeout", 10);
    check("echo_pops", n_pop - p0, 2);
    check("echo_sends", n_send - s0, 1);
    check("echo_data", send_val, 32'h42424242);
    check("echo_latency", last_send_cyc - last_pop_cyc, 2);
    check("echo_wait_state", current_state, 7);
    // A byte queued during WAIT_TX must stay in the FIFO.
    push(8'h04);
    repeat (10) tick();
    check("echo_hold_state", current_state, 7);
    check("echo_hold_data", sendData, 32'h42424242);
    check("echo_no_more_pops", n_pop - p0, 2);
    check("echo_no_more_sends", n_send - s0, 1);
    check("echo_queued", q.size(), 1);
    pulse_done();
    check("echo_done_idle", current_state, 0);

    // ---------------- echo wrap 0xFF ----------------
    p0 = n_pop; s0 = n_send;
    tick();  // IDLE pops queued 0x04
    tick();  // DECODE
    repeat (3) tick();
    check("wrap_waiting", current_state, 5);
    pulse_done();  // stray done outside WAIT_TX
    check("wrap_stray_done", current_state, 5);
    check("wrap_no_send_yet", n_send - s0, 0);
    push(8'hFF);
    run_until_send("wrap_send_timeout", 8);
    check("wrap_data", send_val, 32'h00000000);
    check("wrap_latency", last_send_cyc - last_pop_cyc, 2);
    check("wrap_pops", n_pop - p0, 2);
    pulse_done();
    check("wrap_done_idle", current_state, 0);

    // ---------------- run, 37 enable cycles ----------------
    c0 = n_clken; s0 = n_send;
    dbg_data = 32'h11111111;
    push(8'h01);
    tick();
    tick();
    check("run_state", current_state, 2);
    repeat (37) tick();
    program_finished = 1'b1;
    dbg_data = 32'hCAFEF00D;
    tick();
    dbg_data = 32'h12345678;
    run_until_send("run_send_timeout", 4);
    check("run_clken_cycles", n_clken - c0, 37);
    check("run_data", send_val, 32'hCAFEF00D);
    pulse_done();
    program_finished = 1'b0;
    check("run_done_idle", current_state, 0);

    // ---------------- step then pipeline reset ----------------
    c0 = n_clken; s0 = n_send;
    dbg_data = 32'hA5A55A5A;
    push(8'h02);
    run_until_send("step_send_timeout", 8);
    check("step_clken", n_clken - c0, 1);
    check("step_data", send_val, 32'hA5A55A5A);
    check("step_latency", last_send_cyc - last_pop_cyc, 4);
    pulse_done();
    c0 = n_clken; s0 = n_send; r0 = n_prst;
    push(8'h03);
    tick();
    tick();
    check("prst_state", current_state, 4);
    repeat (10) tick();
    check("prst_cycles", n_prst - r0, 4);
    check("prst_no_send", n_send - s0, 0);
    check("prst_no_clken", n_clken - c0, 0);
    check("prst_idle", current_state, 0);

    // ---------------- bad opcode followed by dump ----------------
    e0 = n_err; s0 = n_send; p0 = n_pop;
    dbg_data = 32'h600DF00D;
    push(8'h7E);
    push(8'h05);
    run_until_send("dump_send_timeout", 10);
    check("bad_cmd_error", n_err - e0, 1);
    check("dump_sends", n_send - s0, 1);
    check("dump_data", send_val, 32'h600DF00D);
    check("dump_latency", last_send_cyc - last_pop_cyc, 2);
    check("dump_pops", n_pop - p0, 2);
    pulse_done();
    check("dump_done_idle", current_state, 0);

    // ---------------- asynchronous reset mid-RUN ----------------
    s0 = n_send;
    push(8'h01);
    tick();
    tick();
    tick();
    check("mid_run_clken", pipeline_clk_en, 1);
    #2;
    global_reset_n = 1'b0;
    #1;
    check("arst_state", current_state, 0);
    check("arst_outs", {rd_uart, pipeline_reset, pipeline_clk_en, send_signal, cmd_error}, 0);
    check("arst_senddata", sendData, 0);
    repeat (2) tick();
    global_reset_n = 1'b1;
    repeat (10) tick();
    check("arst_no_send", n_send - s0, 0);
    check("arst_idle", current_state, 0);

    // ---------------- global invariants ----------------
    check("pop_without_ready", n_bad_pop, 0);
    check("reset_clken_overlap", n_overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debugger_rx_cmd.md
Name: debugger_rx_cmd

Overview:
- Parametrised command receiver between the UART RX FIFO and the MIPS pipeline / debug TX path.
- Pops command bytes from the RX FIFO, decodes them, and drives pipeline control: run, single-step and reset.
- Builds a multi-byte payload (echo or pipeline debug snapshot) and hands it to the TX module with a send/done handshake.
- Successor to the single-mode echo receiver: payload width, echo increment and reset length are parametrised; adds an FSM, pipeline control, and TX-completion wait.

Parameters:
DATA_BYTES, 215, payload length in bytes; payload width PW = 8*DATA_BYTES
ECHO_INC, 1, 8-bit value added (mod 256) to the echoed byte before replication
RESET_CYCLES, 4, number of cycles pipeline_reset is held high by the RESET command (minimum 1)

Ports:
clk  in  1  system clock, all logic on rising edge
global_reset_n  in  1  asynchronous, active-low reset
r_data  in  8  head byte of the RX FIFO, valid while rx_ready=1
rx_ready  in  1  RX FIFO non-empty
program_finished  in  1  pipeline reached end of program (level)
dbg_data  in  PW  pipeline debug snapshot (registers/latches), sampled on dump
data_sent  in  1  TX module finished transmitting the current payload (one-cycle pulse)
rd_uart  out  1  one-cycle pop strobe to the RX FIFO
pipeline_reset  out  1  pipeline synchronous reset request
pipeline_clk_en  out  1  pipeline clock enable
send_signal  out  1  one-cycle strobe: sendData is valid, start TX
sendData  out  PW  payload to TX module
cmd_error  out  1  one-cycle pulse on an unknown opcode
current_state  out  3  FSM state encoding, for LEDs/debug

Behaviour:
- Reset (global_reset_n=0, asynchronous):
  - All outputs are 0; sendData=0.
  - FSM enters IDLE (current_state=0).
  - Internal command register and counters are cleared.
  - Reset asserted mid-operation aborts any command immediately; no send_signal follows.
- State encodings: IDLE=0, DECODE=1, RUN=2, STEP=3, PRST=4, ECHO=5, SEND=6, WAIT_TX=7.
- RX pop rule:
  - In IDLE or ECHO with rx_ready=1: latch r_data and assert rd_uart for exactly that one cycle.
  - rd_uart is never asserted when rx_ready=0, nor in any other state.
  - Bytes arriving in other states stay queued in the FIFO.
- IDLE: on pop, go to DECODE.
- DECODE (1 cycle), opcode to next state:
  - 0x01 RUN -> RUN.
  - 0x02 STEP -> STEP.
  - 0x03 RESET -> PRST.
  - 0x04 ECHO -> ECHO.
  - 0x05 DUMP -> SEND, with sendData <= dbg_data captured this cycle.
  - Any other opcode: cmd_error=1 for one cycle, then IDLE.
- RUN:
  - pipeline_clk_en=1 every cycle while program_finished=0.
  - On the first cycle program_finished=1: pipeline_clk_en=0, sendData <= dbg_data, go to SEND.
  - If program_finished is already 1 on entry, no enable cycle is issued.
- STEP: pipeline_clk_en=1 for exactly one cycle, then capture dbg_data on the following cycle and go to SEND (2 cycles total).
- PRST:
  - pipeline_reset=1 for exactly RESET_CYCLES cycles; pipeline_clk_en=0 throughout.
  - Then IDLE; no TX.
- ECHO:
  - Wait indefinitely for the next byte b and pop it.
  - sendData <= DATA_BYTES copies of ((b+ECHO_INC) mod 256); any carry is discarded, so 0xFF+1 -> 0x00.
  - Then go to SEND.
- SEND: send_signal=1 for one cycle, then WAIT_TX.
- WAIT_TX:
  - Hold sendData stable until data_sent=1, then IDLE.
  - sendData keeps its value in IDLE; it changes only on a new capture.
  - A data_sent pulse outside WAIT_TX is ignored.
- Latency:
  - DUMP: byte in FIFO at IDLE cycle t -> send_signal at t+2.
  - ECHO: second byte popped at cycle u -> send_signal at u+2.
- Back-to-back commands: the next command is popped no earlier than the cycle after returning to IDLE. A full FIFO causes no data loss in this block.
- pipeline_reset and pipeline_clk_en are never high in the same cycle.

Test Plan:
- Reset: drive global_reset_n low mid-RUN, asynchronously between edges -> all outputs 0 immediately, current_state=0; after release, no send_signal.
- Echo with DATA_BYTES=4, ECHO_INC=1: FIFO holds 0x04, 0x41 -> two rd_uart pulses, send_signal once, sendData=0x42424242; hold data_sent low 10 cycles -> sendData stable, no further pops.
- Echo wrap: FIFO holds 0x04, 0xFF -> every sendData byte = 0x00; data_sent pulse -> IDLE.
- Run: FIFO holds 0x01; program_finished rises after 37 cycles -> exactly 37 pipeline_clk_en cycles, then send_signal with sendData = dbg_data value from that cycle.
- Step then reset: FIFO holds 0x02, then 0x03 after data_sent -> one pipeline_clk_en cycle and a dump; then pipeline_reset high exactly RESET_CYCLES=4 cycles, no send_signal.
- Bad opcode with queued data: FIFO holds 0x7E, 0x05 -> cmd_error one cycle, no TX for 0x7E; then the DUMP command proceeds normally; rd_uart never high while rx_ready=0.
